// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - address map constants, region enum and address decoder
//
// Purpose: shared definitions for the data-memory responder and its bench.
//   ADDR_*       : word addresses of the memory-mapped I/O registers
//   region_e     : decoded target of a dmem access
//   decode_addr  : full 32-bit, word-granular decode (addr bits [1:0] ignored)
package dmem_pkg;

  localparam logic [31:0] RAM_BASE      = 32'h0000_0000;
  localparam logic [31:0] ADDR_LEDR     = 32'h1000_0000;
  localparam logic [31:0] ADDR_SW       = 32'h1000_0004;
  localparam logic [31:0] ADDR_MTIME    = 32'h1000_0008;
  localparam logic [31:0] ADDR_MTIMECMP = 32'h1000_000C;
  localparam logic [31:0] ADDR_TSTAT    = 32'h1000_0010;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_LEDR,
    REG_SW,
    REG_MTIME,
    REG_MTIMECMP,
    REG_TSTAT,
    REG_NONE
  } region_e;

  // Comparisons are done on word addresses so the byte-offset bits never
  // influence the decode.
  function automatic region_e decode_addr(input logic [31:0] addr,
                                          input logic [31:0] ram_words);
    logic [31:0] w_word;
    w_word = addr >> 2;
    if (w_word < ((ram_words + (RAM_BASE >> 2))) && w_word >= (RAM_BASE >> 2))
      return REG_RAM;
    else if (w_word == (ADDR_LEDR >> 2))     return REG_LEDR;
    else if (w_word == (ADDR_SW >> 2))       return REG_SW;
    else if (w_word == (ADDR_MTIME >> 2))    return REG_MTIME;
    else if (w_word == (ADDR_MTIMECMP >> 2)) return REG_MTIMECMP;
    else if (w_word == (ADDR_TSTAT >> 2))    return REG_TSTAT;
    else                                     return REG_NONE;
  endfunction

endpackage

// File: rtl/dmem_responder_mmio_timer.sv
// rtl/dmem_responder_mmio_timer.sv - free-running MTIME, MTIMECMP and sticky match flag
//
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_mtime_we         : load MTIME from i_wdata (wins over the increment)
//   i_mtimecmp_we      : load MTIMECMP from i_wdata
//   i_tstat_we         : TSTAT write; i_wdata[0]=1 clears the flag
//   i_wdata            : write data
//   o_mtime            : current MTIME
//   o_mtimecmp         : current MTIMECMP
//   o_flag             : sticky match flag
module mmio_timer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mtime_we,
  input  logic        i_mtimecmp_we,
  input  logic        i_tstat_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_mtime,
  output logic [31:0] o_mtimecmp,
  output logic        o_flag
);

  logic [31:0] r_mtime;
  logic [31:0] r_mtimecmp;
  logic        r_flag;
  logic [31:0] w_mtime_nxt;
  logic        w_match;
  logic        w_clear;

  // The match is evaluated on the value MTIME is about to take, so a direct
  // MTIME write of the compare value raises the flag on that same edge.
  assign w_mtime_nxt = i_mtime_we ? i_wdata : r_mtime + 32'd1;
  assign w_match     = (w_mtime_nxt == r_mtimecmp);
  assign w_clear     = i_tstat_we & i_wdata[0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mtime    <= 32'd0;
      r_mtimecmp <= 32'hFFFF_FFFF;
      r_flag     <= 1'b0;
    end else begin
      r_mtime <= w_mtime_nxt;
      if (i_mtimecmp_we) r_mtimecmp <= i_wdata;
      // Set has priority over a simultaneous clear.
      if (w_match)      r_flag <= 1'b1;
      else if (w_clear) r_flag <= 1'b0;
    end
  end

  assign o_mtime    = r_mtime;
  assign o_mtimecmp = r_mtimecmp;
  assign o_flag     = r_flag;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word RAM plus LED/switch/timer MMIO behind the core dmem port
//
// Ports:
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_dmem_we/re       : write / read strobes from the core
//   i_dmem_addr        : byte address, bits [1:0] ignored
//   i_dmem_wdata       : write data
//   o_dmem_rdata       : combinational read data (0 when re=0 or unmapped)
//   i_sw               : asynchronous board switches
//   o_ledr             : LED register
//   o_timer_irq        : timer match flag (level)
//   o_bus_err          : one-cycle pulse after an unmapped access
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DMEM_WORDS = 1024,
  parameter int LED_W      = 10,
  parameter int SW_W       = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_dmem_we,
  input  logic             i_dmem_re,
  input  logic [31:0]      i_dmem_addr,
  input  logic [31:0]      i_dmem_wdata,
  output logic [31:0]      o_dmem_rdata,
  input  logic [SW_W-1:0]  i_sw,
  output logic [LED_W-1:0] o_ledr,
  output logic             o_timer_irq,
  output logic             o_bus_err
);

  localparam int AW = $clog2(DMEM_WORDS);

  region_e          w_region;
  logic             w_we;
  logic [AW-1:0]    w_idx;
  logic [31:0]      w_mtime;
  logic [31:0]      w_mtimecmp;
  logic             w_flag;

  logic [31:0]      r_ram [DMEM_WORDS];
  logic [LED_W-1:0] r_ledr;
  logic [SW_W-1:0]  r_sw_meta;
  logic [SW_W-1:0]  r_sw_sync;
  logic             r_bus_err;

  assign w_region = decode_addr(i_dmem_addr, 32'(DMEM_WORDS));
  assign w_idx    = i_dmem_addr[AW+1:2];
  // Gating with reset keeps a write in the reset cycle out of the RAM too.
  assign w_we     = i_dmem_we & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (w_we && w_region == REG_RAM) r_ram[w_idx] <= i_dmem_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ledr    <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_bus_err <= 1'b0;
    end else begin
      if (w_we && w_region == REG_LEDR) r_ledr <= i_dmem_wdata[LED_W-1:0];
      r_sw_meta <= i_sw;
      r_sw_sync <= r_sw_meta;
      r_bus_err <= (i_dmem_we | i_dmem_re) && (w_region == REG_NONE);
    end
  end

  mmio_timer u_timer (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_mtime_we    (w_we && w_region == REG_MTIME),
    .i_mtimecmp_we (w_we && w_region == REG_MTIMECMP),
    .i_tstat_we    (w_we && w_region == REG_TSTAT),
    .i_wdata       (i_dmem_wdata),
    .o_mtime       (w_mtime),
    .o_mtimecmp    (w_mtimecmp),
    .o_flag        (w_flag)
  );

  // Reads see register state before the edge, so a same-cycle write returns
  // the old value.
  always_comb begin
    o_dmem_rdata = 32'd0;
    if (i_dmem_re) begin
      case (w_region)
        REG_RAM:      o_dmem_rdata = r_ram[w_idx];
        REG_LEDR:     o_dmem_rdata = 32'(r_ledr);
        REG_SW:       o_dmem_rdata = 32'(r_sw_sync);
        REG_MTIME:    o_dmem_rdata = w_mtime;
        REG_MTIMECMP: o_dmem_rdata = w_mtimecmp;
        REG_TSTAT:    o_dmem_rdata = {31'd0, w_flag};
        default:      o_dmem_rdata = 32'd0;
      endcase
    end
  end

  assign o_ledr      = r_ledr;
  assign o_timer_irq = w_flag;
  assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector table plus timer/sync/reset sequences
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, re;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic [9:0]  sw;
  logic [9:0]  ledr;
  logic        irq, berr;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DMEM_WORDS(1024), .LED_W(10), .SW_W(10)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_dmem_we    (we),
    .i_dmem_re    (re),
    .i_dmem_addr  (addr),
    .i_dmem_wdata (wdata),
    .o_dmem_rdata (rdata),
    .i_sw         (sw),
    .o_ledr       (ledr),
    .o_timer_irq  (irq),
    .o_bus_err    (berr)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [9:0]  exp_led;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; re = 1'b0; addr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    re = 1'b1; addr = a;
    #1;
    d = rdata;
    re = 1'b0;
  endtask

  initial begin
    logic [31:0] v;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h1111_1111, 32'h0,         10'h000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h1111_1111, 10'h000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 10'h000, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'hA5A5_A5A5, 32'h0,         10'h000, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0FFE, 32'h0,         32'hA5A5_A5A5, 10'h000, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0,         32'h0,         10'h000, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 10'h000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, ADDR_LEDR,     32'h0000_03FF, 32'h0,         10'h3FF, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, ADDR_LEDR,     32'h0,         32'h0000_03FF, 10'h3FF, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, ADDR_LEDR,     32'hFFFF_F000, 32'h0000_03FF, 10'h000, 1'b0};
    vecs[10] = '{1'b1, 1'b1, ADDR_SW,       32'hFFFF_FFFF, 32'h0,         10'h000, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h2000_0000, 32'h0000_0001, 32'h0,         10'h000, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h2000_0000, 32'h0,         32'h0,         10'h000, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 32'h1000_0014, 32'h0,         32'h0,         10'h000, 1'b1};
    vecs[14] = '{1'b0, 1'b0, ADDR_LEDR,     32'h0,         32'h0,         10'h000, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 10'h000, 1'b0};

    rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; sw = '0;
    cyc(); cyc();
    chk("reset_ledr", 32'(ledr), 32'h0);
    chk("reset_irq",  32'(irq),  32'h0);
    chk("reset_berr", 32'(berr), 32'h0);
    rst = 1'b0;
    rd(ADDR_MTIME, v);    chk("reset_mtime", v, 32'h0);
    rd(ADDR_MTIMECMP, v); chk("reset_mtimecmp", v, 32'hFFFF_FFFF);
    rd(ADDR_TSTAT, v);    chk("reset_tstat", v, 32'h0);
    cyc();

    for (int i = 0; i < 16; i++) begin
      we = vecs[i].we; re = vecs[i].re; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      cyc();
      chk($sformatf("vec%0d_ledr", i), 32'(ledr), 32'(vecs[i].exp_led));
      chk($sformatf("vec%0d_berr", i), 32'(berr), 32'(vecs[i].exp_err));
    end
    we = 1'b0; re = 1'b0;

    // Switch synchronizer: two edges of latency.
    sw = 10'h155;
    rd(ADDR_SW, v); chk("sw_edge0", v, 32'h0);
    cyc();
    rd(ADDR_SW, v); chk("sw_edge1", v, 32'h0);
    cyc();
    rd(ADDR_SW, v); chk("sw_edge2", v, 32'h155);

    // Timer match 16 cycles after writing MTIME.
    wr(ADDR_MTIME, 32'h0000_1000);
    wr(ADDR_MTIMECMP, 32'h0000_0020);
    wr(ADDR_MTIME, 32'h0000_0010);
    for (int k = 0; k <= 17; k++) begin
      chk($sformatf("irq_after_%0d", k), 32'(irq), (k >= 16) ? 32'h1 : 32'h0);
      cyc();
    end
    rd(ADDR_TSTAT, v); chk("tstat_set", v, 32'h1);
    wr(ADDR_TSTAT, 32'h1);
    chk("irq_cleared", 32'(irq), 32'h0);

    // MTIME write wins over increment and is compared directly.
    wr(ADDR_MTIMECMP, 32'h0000_0040);
    wr(ADDR_MTIME, 32'h0000_0040);
    chk("irq_on_write_match", 32'(irq), 32'h1);
    rd(ADDR_MTIME, v); chk("mtime_write_wins", v, 32'h40);
    wr(ADDR_TSTAT, 32'h1);
    chk("irq_cleared2", 32'(irq), 32'h0);

    // Clear on the exact match edge: set wins.
    wr(ADDR_MTIME, 32'h0000_003F);
    chk("irq_before_match", 32'(irq), 32'h0);
    wr(ADDR_TSTAT, 32'h1);
    chk("irq_set_beats_clear", 32'(irq), 32'h1);

    // MTIME wrap.
    wr(ADDR_MTIME, 32'hFFFF_FFFE);
    rd(ADDR_MTIME, v); chk("wrap_fffffffe", v, 32'hFFFF_FFFE);
    cyc();
    rd(ADDR_MTIME, v); chk("wrap_ffffffff", v, 32'hFFFF_FFFF);
    cyc();
    rd(ADDR_MTIME, v); chk("wrap_zero", v, 32'h0);

    // Reset during writes discards them.
    wr(ADDR_LEDR, 32'h0000_0155);
    chk("ledr_pre_reset", 32'(ledr), 32'h155);
    rst = 1'b1; we = 1'b1; addr = ADDR_LEDR; wdata = 32'h0000_02AA;
    cyc();
    chk("ledr_reset_write", 32'(ledr), 32'h0);
    addr = 32'h0000_0010; wdata = 32'h1234_5678;
    cyc();
    rst = 1'b0; we = 1'b0;
    rd(32'h0000_0010, v); chk("ram_reset_write", v, 32'h0);
    chk("irq_after_reset", 32'(irq), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
